// File: rtl/lcd_bus_writer.sv
// Buffered 8080-style LCD write engine: FIFO-queued command/data words driven onto CS/RS/WR/DATA.
// Define LCD_FILL_EN to add in_count, a per-word repeat count for solid-colour fills.
module lcd_bus_writer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned WR_LOW   = 2,
  parameter int unsigned WR_HIGH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_rs,
  input  logic [15:0]            in_data,
`ifdef LCD_FILL_EN
  input  logic [16:0]            in_count,
`endif
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   LCD_CS,
  output logic                   LCD_RS,
  output logic                   LCD_WR,
  output logic                   LCD_RD,
  output logic [15:0]            LCD_DATA
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef LCD_FILL_EN
  localparam int unsigned EW = 34;
`else
  localparam int unsigned EW = 17;
`endif
  localparam int unsigned MaxPh = (CS_SETUP > WR_LOW) ?
                                  ((CS_SETUP > WR_HIGH) ? CS_SETUP : WR_HIGH) :
                                  ((WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH);
  localparam int unsigned CntW = $clog2(MaxPh + 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] LowLd   = CntW'(WR_LOW - 1);
  localparam logic [CntW-1:0] HighLd  = CntW'(WR_HIGH - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StWrLo, StWrHi} state_e;

  // FIFO storage; pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [EW-1:0] in_entry, head;
  logic          push, pop, empty, full;
  logic          head_rs;
  logic [15:0]   head_data;

`ifdef LCD_FILL_EN
  logic [16:0] head_rep;
  logic [16:0] rep_q, rep_d;
  assign in_entry = {in_rs, in_data, in_count};
  assign head_rep = (head[16:0] == 17'd0) ? 17'd1 : head[16:0];
`else
  assign in_entry = {in_rs, in_data};
`endif

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign head_rs   = head[EW-1];
  assign head_data = head[EW-2 -: 16];
  assign level     = wptr_q - rptr_q;
  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (wptr_q == rptr_q);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_entry;
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cs_q, cs_d, wr_q, wr_d, rs_q, rs_d;
  logic [15:0]     data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_FILL_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          rs_d    = head_rs;
          data_d  = head_data;
`ifdef LCD_FILL_EN
          rep_d   = head_rep;
`endif
          cs_d    = 1'b0;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          wr_d    = 1'b0;
          cnt_d   = LowLd;
          state_d = StWrLo;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrLo: begin
        if (cnt_q == '0) begin
          wr_d    = 1'b1;
          cnt_d   = HighLd;
          state_d = StWrHi;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrHi: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
`ifdef LCD_FILL_EN
        end else if (rep_q > 17'd1) begin
          rep_d   = rep_q - 17'd1;
          wr_d    = 1'b0;
          cnt_d   = LowLd;
          state_d = StWrLo;
`endif
        end else if (!empty) begin
          // Stream the next word: CS stays low and RS/DATA change together with the WR fall.
          pop     = 1'b1;
          rs_d    = head_rs;
          data_d  = head_data;
`ifdef LCD_FILL_EN
          rep_d   = head_rep;
`endif
          wr_d    = 1'b0;
          cnt_d   = LowLd;
          state_d = StWrLo;
        end else begin
          cs_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= '0;
`ifdef LCD_FILL_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
`ifdef LCD_FILL_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign busy     = ~empty | (state_q != StIdle);
  assign LCD_CS   = cs_q;
  assign LCD_WR   = wr_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_RD   = 1'b1;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Self-checking bench for lcd_bus_writer: cycle-exact strobe checks plus a queue scoreboard
// of the words latched on every WR rising edge.
module tb_lcd_bus_writer;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CS_SETUP = 1;
  localparam int unsigned WR_LOW   = 2;
  localparam int unsigned WR_HIGH  = 2;
  localparam int unsigned PERIOD   = WR_LOW + WR_HIGH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_rs = 1'b0;
  logic [15:0] in_data = 16'h0;
`ifdef LCD_FILL_EN
  logic [16:0] in_count = 17'd1;
`endif
  logic        in_ready, busy;
  logic [3:0]  level;
  logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD;
  logic [15:0] LCD_DATA;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  int          cs_falls = 0;
  int          anomalies = 0;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .DEPTH   (DEPTH),
    .CS_SETUP(CS_SETUP),
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs   (in_rs),
    .in_data (in_data),
`ifdef LCD_FILL_EN
    .in_count(in_count),
`endif
    .busy    (busy),
    .level   (level),
    .LCD_CS  (LCD_CS),
    .LCD_RS  (LCD_RS),
    .LCD_WR  (LCD_WR),
    .LCD_RD  (LCD_RD),
    .LCD_DATA(LCD_DATA)
  );

  // Bus monitor: records the word present at each WR rising edge (except one caused by reset).
  logic        prev_wr = 1'b1;
  logic        prev_cs = 1'b1;
  logic        prev_rst = 1'b1;
  logic [16:0] low_word = 17'h0;
  always @(negedge clk) begin
    if (LCD_WR === 1'b0 && LCD_CS !== 1'b0) anomalies++;
    if (LCD_RD !== 1'b1) anomalies++;
    if (prev_wr === 1'b0 && LCD_WR === 1'b1 && prev_rst !== 1'b1) begin
      if ({LCD_RS, LCD_DATA} !== low_word) anomalies++;
      obs_q.push_back({LCD_RS, LCD_DATA});
    end
    if (prev_cs === 1'b1 && LCD_CS === 1'b0) cs_falls++;
    if (LCD_WR === 1'b0) low_word <= {LCD_RS, LCD_DATA};
    prev_wr  <= LCD_WR;
    prev_cs  <= LCD_CS;
    prev_rst <= rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one cycle; the model expands it into the writes it must produce.
  task automatic push_word(input logic rs, input logic [15:0] d);
    int reps;
    reps = 1;
`ifdef LCD_FILL_EN
    reps = (in_count == 17'd0) ? 1 : int'(in_count);
`endif
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    if (in_ready === 1'b1) begin
      for (int i = 0; i < reps; i++) exp_q.push_back({rs, d});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || LCD_CS !== 1'b1) && n < 300) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks += 8;
    if (LCD_CS !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", LCD_CS); end
    if (LCD_WR !== 1'b1) begin errors++; $display("FAIL reset_wr: got %b want 1", LCD_WR); end
    if (LCD_RD !== 1'b1) begin errors++; $display("FAIL reset_rd: got %b want 1", LCD_RD); end
    if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
    if (LCD_DATA !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0000", LCD_DATA);
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
  endtask

  task automatic test_single();
    int  obs_base;
    logic exp_cs, exp_wr, exp_busy;
    logic [3:0] exp_lvl;
    exp_q.delete();
    obs_base = obs_q.size();
    push_word(1'b0, 16'h002C);
    // Cycle k relative to the accept cycle N.
    for (int k = 1; k <= 9; k++) begin
      exp_cs   = !(k >= 2 && k < 2 + CS_SETUP + PERIOD);
      exp_wr   = !(k >= 2 + CS_SETUP && k < 2 + CS_SETUP + WR_LOW);
      exp_busy = (k < 2 + CS_SETUP + PERIOD);
      exp_lvl  = (k == 1) ? 4'd1 : 4'd0;
      checks += 4;
      if (LCD_CS !== exp_cs) begin
        errors++; $display("FAIL single_cs N+%0d: got %b want %b", k, LCD_CS, exp_cs);
      end
      if (LCD_WR !== exp_wr) begin
        errors++; $display("FAIL single_wr N+%0d: got %b want %b", k, LCD_WR, exp_wr);
      end
      if (busy !== exp_busy) begin
        errors++; $display("FAIL single_busy N+%0d: got %b want %b", k, busy, exp_busy);
      end
      if (level !== exp_lvl) begin
        errors++; $display("FAIL single_level N+%0d: got %0d want %0d", k, level, exp_lvl);
      end
      if (k == 2 + CS_SETUP + WR_LOW) begin
        checks++;
        if ({LCD_RS, LCD_DATA} !== 17'h0002C) begin
          errors++; $display("FAIL single_word: got %b/%h want 0/002c", LCD_RS, LCD_DATA);
        end
      end
      step();
    end
    wait_idle("single");
    checks++;
    if (obs_q.size() - obs_base != 1) begin
      errors++; $display("FAIL single_count: got %0d writes want 1", obs_q.size() - obs_base);
    end
  endtask

  task automatic test_stream();
    logic        rs_tab[3];
    logic [15:0] d_tab[3];
    int          obs_base, falls_base, a_base;
    logic        exp_cs, exp_wr;
    rs_tab = '{1'b0, 1'b1, 1'b1};
    d_tab  = '{16'h002A, 16'h0000, 16'h00EF};
    exp_q.delete();
    obs_base   = obs_q.size();
    falls_base = cs_falls;
    a_base     = anomalies;
    for (int k = 0; k < 22; k++) begin
      exp_cs = !(k >= 2 && k < 2 + CS_SETUP + 3 * PERIOD);
      exp_wr = !(k >= 2 + CS_SETUP && k < 2 + CS_SETUP + 3 * PERIOD &&
                 ((k - 2 - CS_SETUP) % PERIOD) < WR_LOW);
      checks += 2;
      if (LCD_CS !== exp_cs) begin
        errors++; $display("FAIL stream_cs N+%0d: got %b want %b", k, LCD_CS, exp_cs);
      end
      if (LCD_WR !== exp_wr) begin
        errors++; $display("FAIL stream_wr N+%0d: got %b want %b", k, LCD_WR, exp_wr);
      end
      if (k < 3) push_word(rs_tab[k], d_tab[k]);
      else step();
    end
    wait_idle("stream");
    checks += 3;
    if (cs_falls - falls_base != 1) begin
      errors++; $display("FAIL stream_cs_windows: got %0d want 1", cs_falls - falls_base);
    end
    if (anomalies != a_base) begin
      errors++; $display("FAIL stream_bus_rules: got %0d violations want 0", anomalies - a_base);
    end
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++;
      $display("FAIL stream_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        checks++;
        if (obs_q[obs_base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stream_word[%0d]: got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int obs_base, a_base;
    exp_q.delete();
    obs_base = obs_q.size();
    a_base   = anomalies;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(1, 0) == 1) push_word(1'($urandom), 16'($urandom));
      else step();
    end
    wait_idle("random");
    checks += 2;
    if (anomalies != a_base) begin
      errors++; $display("FAIL random_bus_rules: got %0d violations want 0", anomalies - a_base);
    end
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        checks++;
        if (obs_q[obs_base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_word[%0d]: got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
        end
      end
    end
  endtask

  // Continuous supply from an idle, empty block: pops happen at the first IDLE cycle and then
  // in the last WR-high cycle of each write, so occupancy follows from arithmetic alone.
  task automatic test_full();
    int          obs_base, mlvl, last_pop;
    logic        push_ok, pop_now;
    logic [16:0] w;
    exp_q.delete();
    obs_base = obs_q.size();
    mlvl     = 0;
    last_pop = 2 + CS_SETUP + PERIOD - 1;
    for (int k = 0; k < 40; k++) begin
      checks += 2;
      if (level !== 4'(mlvl)) begin
        errors++; $display("FAIL full_level N+%0d: got %0d want %0d", k, level, mlvl);
      end
      if (in_ready !== (mlvl < DEPTH)) begin
        errors++; $display("FAIL full_ready N+%0d: got %b want %b", k, in_ready, mlvl < DEPTH);
      end
      w        = 17'($urandom);
      in_valid = 1'b1;
      in_rs    = w[16];
      in_data  = w[15:0];
      push_ok  = (mlvl < DEPTH);
      pop_now  = (mlvl > 0) && (k == 1 || (k >= last_pop && (k - last_pop) % PERIOD == 0));
      if (push_ok) exp_q.push_back(w);
      mlvl = mlvl + int'(push_ok) - int'(pop_now);
      step();
    end
    in_valid = 1'b0;
    wait_idle("full");
    checks++;
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++;
      $display("FAIL full_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        checks++;
        if (obs_q[obs_base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL full_word[%0d]: got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef LCD_FILL_EN
  task automatic test_fill();
    int obs_base;
    exp_q.delete();
    obs_base = obs_q.size();
    in_count = 17'd5;
    push_word(1'b1, 16'hF800);
    wait_idle("fill5");
    in_count = 17'd0;
    push_word(1'b0, 16'h1234);
    wait_idle("fill0");
    in_count = 17'd1;
    checks++;
    if (obs_q.size() - obs_base != 6) begin
      errors++; $display("FAIL fill_count: got %0d want 6", obs_q.size() - obs_base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        checks++;
        if (obs_q[obs_base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fill_word[%0d]: got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int obs_base, falls_base, n;
    exp_q.delete();
    push_word(1'b0, 16'h0011);
    push_word(1'b1, 16'h0022);
    push_word(1'b1, 16'h0033);
    obs_base = obs_q.size();
    n = 0;
    while (LCD_WR !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (LCD_WR !== 1'b0) begin
      errors++; $display("FAIL rstmid_reach_wr_lo: got WR=%b want 0 within 20 cycles", LCD_WR);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 5;
    if (LCD_CS !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b want 1", LCD_CS); end
    if (LCD_WR !== 1'b1) begin errors++; $display("FAIL rstmid_wr: got %b want 1", LCD_WR); end
    if (level !== 4'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    falls_base = cs_falls;
    repeat (20) step();
    checks += 2;
    if (obs_q.size() != obs_base) begin
      errors++; $display("FAIL rstmid_strobes: got %0d writes want 0", obs_q.size() - obs_base);
    end
    if (cs_falls != falls_base) begin
      errors++; $display("FAIL rstmid_cs_after: got %0d CS falls want 0", cs_falls - falls_base);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_full();
`ifdef LCD_FILL_EN
    test_fill();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
